// File: rtl/adc_bcd_if.sv
// adc_bcd_if: sample-in / digits-out bundle for the ADC BCD converter.
//   i_data, i_data_valid : unsigned sample plus a one-cycle strobe (producer -> converter)
//   o_ones..o_thousands  : BCD digits of the last completed conversion
//   o_done               : one-cycle pulse when the digits update
//   o_busy               : conversion in flight; samples are not accepted
//   o_overrun            : one-cycle pulse, a sample arrived while busy
// master = sample producer / display consumer side, slave = converter.
interface adc_bcd_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] i_data;
  logic              i_data_valid;
  logic [3:0]        o_ones;
  logic [3:0]        o_tens;
  logic [3:0]        o_hundreds;
  logic [3:0]        o_thousands;
  logic              o_done;
  logic              o_busy;
  logic              o_overrun;

  modport master (
    output i_data, i_data_valid,
    input  o_ones, o_tens, o_hundreds, o_thousands, o_done, o_busy, o_overrun
  );

  modport slave (
    input  i_data, i_data_valid,
    output o_ones, o_tens, o_hundreds, o_thousands, o_done, o_busy, o_overrun
  );
endinterface

// File: rtl/adc_bcd_conv.sv
// adc_bcd_conv: iterative double-dabble conversion of an ADC sample into four
// BCD digits, one binary bit per clock.
//   clk   : system clock, rising edge
//   reset : synchronous, active high
//   bus   : adc_bcd_if.slave (sample in, digits/done/busy/overrun out)
// Optional feature macro ADC_BCD_AVG_EN: average 2^AVG_LOG2 accepted samples
// and convert the truncated mean instead of every sample.
module adc_bcd_conv #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic      clk,
  input  logic      reset,
  adc_bcd_if.slave  bus
);
  localparam int W_W   = 16 + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  // Elaboration-time parameter range guard.
  if (DATA_W < 4 || DATA_W > 13) begin : g_bad_data_w
    $error("adc_bcd_conv: DATA_W out of range 4..13");
  end
  if (AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_bad_avg_log2
    $error("adc_bcd_conv: AVG_LOG2 out of range 1..4");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [W_W-1:0]    work_q;     // {bcd[15:0], binary[DATA_W-1:0]}
  logic [W_W-1:0]    work_nxt;
  logic [15:0]       bcd_adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              start;
  logic [DATA_W-1:0] start_val;
  logic              last_iter;
  logic [15:0]       digits_q;
  logic              done_q;
  logic              overrun_q;

  assign accept    = (state_q == IDLE) && bus.i_data_valid;
  assign last_iter = (state_q == SHIFT) && (cnt_q == CNT_W'(DATA_W - 1));

`ifdef ADC_BCD_AVG_EN
  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_sum;
  logic [AVG_LOG2-1:0] nsmp_q;

  // The last sample of a window is summed combinationally so conversion
  // starts with the same latency as direct mode.
  assign acc_sum   = acc_q + ACC_W'(bus.i_data);
  assign start     = accept && (&nsmp_q);
  assign start_val = DATA_W'(acc_sum >> AVG_LOG2);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      nsmp_q <= '0;
    end else if (accept) begin
      nsmp_q <= nsmp_q + AVG_LOG2'(1);
      acc_q  <= start ? '0 : acc_sum;
    end
  end
`else
  assign start     = accept;
  assign start_val = bus.i_data;
`endif

  // Add-3 on every nibble >= 5 (all from the pre-correction value), then shift.
  always_comb begin
    bcd_adj = work_q[W_W-1 -: 16];
    for (int i = 0; i < 4; i++) begin
      if (work_q[DATA_W + 4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = work_q[DATA_W + 4*i +: 4] + 4'd3;
    end
    work_nxt = {bcd_adj, work_q[DATA_W-1:0]} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = SHIFT;
      SHIFT:   if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q    <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= last_iter;
      overrun_q <= bus.i_data_valid && (state_q == SHIFT);
      if (start) begin
        work_q <= {16'd0, start_val};
        cnt_q  <= '0;
      end else if (state_q == SHIFT) begin
        work_q <= work_nxt;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      // Final iteration writes its shifted result straight to the digits.
      if (last_iter) digits_q <= work_nxt[W_W-1 -: 16];
    end
  end

  assign bus.o_ones      = digits_q[3:0];
  assign bus.o_tens      = digits_q[7:4];
  assign bus.o_hundreds  = digits_q[11:8];
  assign bus.o_thousands = digits_q[15:12];
  assign bus.o_done      = done_q;
  assign bus.o_busy      = (state_q == SHIFT);
  assign bus.o_overrun   = overrun_q;
endmodule

// File: doc/adc_bcd_conv.md
# adc_bcd_conv

Converts each 12-bit sample from the SPI ADC reader into four packed BCD digits for the seven-segment display controller. It sits between the SPI front end (producer of data plus a one-cycle data-valid strobe) and the display driver (consumer of ones/tens/hundreds/thousands nibbles), so the display shows the live ADC code. Conversion is iterative shift-add-3 (double-dabble), one bit per clock. Displayed digits hold until the next conversion completes.

## Interface

Parameters:
- `DATA_W`, default 12: sample width; legal range 4..13 so the maximum value (≤8191) fits in four digits.
- `AVG_LOG2`, default 2: log2 of the averaging window; used only when `ADC_BCD_AVG_EN` is defined; legal range 1..4.

Ports:
- `clk`, input, 1: single system clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `i_data`, input, DATA_W: unsigned ADC sample.
- `i_data_valid`, input, 1: one-cycle strobe; `i_data` is valid in that cycle.
- `o_ones`, `o_tens`, `o_hundreds`, `o_thousands`, outputs, 4 each: BCD digits of the last completed conversion.
- `o_done`, output, 1: one-cycle pulse when the digit outputs update.
- `o_busy`, output, 1: high while converting; samples are not accepted.
- `o_overrun`, output, 1: one-cycle pulse when `i_data_valid` arrives while busy.

## Operation

- States: IDLE and SHIFT.
- IDLE: `o_busy` = 0. Each accepted sample either starts a conversion directly or feeds the averager (see Configuration).
- Conversion start: load a work register {16-bit BCD field = 0, binary field = value}, clear the iteration counter, and go to SHIFT.
- SHIFT, one iteration per clock:
  - In every BCD nibble ≥ 5, add 3 (all four nibbles are corrected in parallel from the pre-correction value).
  - Shift the whole register left by 1.
  - Increment the counter.
- After DATA_W iterations, register the BCD field into the four digit outputs, pulse `o_done`, and return to IDLE.
- `i_data_valid` while in SHIFT: the sample is dropped, `o_overrun` pulses the next cycle, and the conversion in flight is unaffected.
- Digit outputs change only on completion. Nibbles are always 0..9. `o_thousands` ≤ 8 (≤ 4 for DATA_W = 12).
- Reset mid-conversion: the conversion is aborted with no `o_done`, and the state goes to IDLE.

## Timing

- Reset values:
  - All digit outputs 0.
  - `o_done`, `o_busy`, `o_overrun` all 0.
  - State IDLE; counter, accumulator and sample count cleared.
- Direct mode, valid in cycle 0 (sample accepted):
  - `o_busy` = 1 in cycles 1..DATA_W.
  - New digits and `o_done` = 1 in cycle DATA_W+1, with `o_busy` = 0 in that cycle.
- A new valid is accepted in cycle DATA_W+1, giving a maximum throughput of one sample per DATA_W+1 cycles (13 for the default).
- `o_overrun` is registered: it asserts the cycle after the rejected valid.
- `o_done` and a new acceptance may share a cycle.

## Configuration

- Macro `ADC_BCD_AVG_EN`:
  - Defined: IDLE accumulates 2^AVG_LOG2 accepted samples into a DATA_W+AVG_LOG2-bit accumulator.
    - On the cycle of the last sample, the converted value is (accumulator + sample) >> AVG_LOG2 (truncated), the accumulator and count clear, and SHIFT begins next cycle (same latency as direct mode, counted from the last sample).
    - Samples dropped while busy are not counted.
  - Undefined: every accepted sample is converted directly; `AVG_LOG2` is unused and no accumulator exists.

## Test plan

- Reset, then check outputs with no stimulus: all digits 0; done, busy and overrun stay 0 for 50 cycles.
- Direct mode, `i_data` = 4095 strobed in cycle 0: digits 4,0,9,5; `o_done` exactly in cycle 13; `o_busy` high in cycles 1..12.
- Direct mode, back-to-back samples 0 then 1234 with valids 13 cycles apart: first result 0,0,0,0, second 1,2,3,4, two done pulses, no overrun.
- Overrun: valid with 999 at cycle 0, then 77 at cycle 5. Result 0,9,9,9; `o_overrun` = 1 at cycle 6; no second done.
- Reset mid-conversion: 2048 strobed, reset asserted in cycle 6. No `o_done`; digits remain at their previous value (0 after reset); the next sample 5 gives 0,0,0,5.
- `ADC_BCD_AVG_EN`, AVG_LOG2 = 2, samples 100, 200, 300, 401 spaced 2 cycles apart: exactly one done, 13 cycles after the fourth valid; digits 0,2,5,0.
